wb_tag_target_slice: RTL and testbench

Registered request/response slice with bus watchdog, placed on one target port of the tagged Wishbone NxN interconnect, between the interconnect and a slow or untrusted target. It captures each request and its address, cycle and data tags, replays it to the target from registers, and returns ack or err as a single-cycle registered pulse. If the target does not answer within a bounded number of cycles, the watchdog terminates the transfer with err, so the interconnect's per-target arbiter is never locked.

---
 rtl/wb_tag_target_slice.sv | 154 +++++++++++++++
 tb/tb_wb_tag_target_slice.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_tag_target_slice.sv
// Registered request/response slice for one tagged Wishbone target port, with ack/err returned as one-cycle pulses.
// Define WB_TAG_SLICE_TIMEOUT_EN to add a watchdog that ends a silent transfer with err after TIMEOUT cycles.
module wb_tag_target_slice #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int TGA_WIDTH = 4,
    parameter int TGC_WIDTH = 4,
    parameter int TGD_WIDTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   adr,
    input  logic [DAT_WIDTH-1:0]   dat_w,
    input  logic [DAT_WIDTH/8-1:0] sel,
    input  logic                   we,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic [TGA_WIDTH-1:0]   tga,
    input  logic [TGC_WIDTH-1:0]   tgc,
    input  logic [TGD_WIDTH-1:0]   tgd_w,
    output logic [DAT_WIDTH-1:0]   dat_r,
    output logic [TGD_WIDTH-1:0]   tgd_r,
    output logic                   ack,
    output logic                   err,
    output logic [ADR_WIDTH-1:0]   tadr,
    output logic [DAT_WIDTH-1:0]   tdat_w,
    output logic [DAT_WIDTH/8-1:0] tsel,
    output logic                   twe,
    output logic                   tcyc,
    output logic                   tstb,
    output logic [TGA_WIDTH-1:0]   ttga,
    output logic [TGC_WIDTH-1:0]   ttgc,
    output logic [TGD_WIDTH-1:0]   ttgd_w,
    input  logic [DAT_WIDTH-1:0]   tdat_r,
    input  logic [TGD_WIDTH-1:0]   ttgd_r,
    input  logic                   tack,
    input  logic                   terr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic finish;
    logic wd_fire;
    logic alive;

    assign accept = (state == IDLE) && cyc && stb;
    assign finish = (state == REQ) && (tack || terr || wd_fire);

`ifdef WB_TAG_SLICE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_count;

    // Fires on the last REQ cycle of the window; a real response that same cycle takes priority.
    assign wd_fire = (state == REQ) && !tack && !terr && (wd_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_count <= '0;
        end else if (accept) begin
            wd_count <= '0;
        end else if ((state == REQ) && !tack && !terr && (wd_count != {CNT_W{1'b1}})) begin
            wd_count <= wd_count + CNT_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign wd_fire        = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (finish) state_next = RSP;
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // alive remembers whether the initiator kept cyc up for the whole transfer; if not, the result is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tadr   <= '0;
            tdat_w <= '0;
            tsel   <= '0;
            twe    <= 1'b0;
            tcyc   <= 1'b0;
            tstb   <= 1'b0;
            ttga   <= '0;
            ttgc   <= '0;
            ttgd_w <= '0;
            dat_r  <= '0;
            tgd_r  <= '0;
            ack    <= 1'b0;
            err    <= 1'b0;
            alive  <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (accept) begin
                tadr   <= adr;
                tdat_w <= dat_w;
                tsel   <= sel;
                twe    <= we;
                ttga   <= tga;
                ttgc   <= tgc;
                ttgd_w <= tgd_w;
                tcyc   <= 1'b1;
                tstb   <= 1'b1;
                alive  <= 1'b1;
            end else if (state == REQ) begin
                if (!cyc) begin
                    alive <= 1'b0;
                end
                if (finish) begin
                    tcyc <= 1'b0;
                    tstb <= 1'b0;
                    if (alive && cyc) begin
                        if (terr || wd_fire) begin
                            err   <= 1'b1;
                            dat_r <= '0;
                            tgd_r <= '0;
                        end else begin
                            ack   <= 1'b1;
                            dat_r <= tdat_r;
                            tgd_r <= ttgd_r;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_tag_target_slice.sv
// Self-checking bench for wb_tag_target_slice: directed vector table, random transfers against a transaction model,
// and hand sequences for back-to-back traffic and asynchronous reset. Expectations follow WB_TAG_SLICE_TIMEOUT_EN.
module tb_wb_tag_target_slice;

    localparam int TIMEOUT = 8;
`ifdef WB_TAG_SLICE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] adr = '0, dat_w = '0, dat_r, tadr, tdat_w, tdat_r = '0;
    logic [3:0]  sel = '0, tsel;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [3:0]  tga = '0, tgc = '0, tgd_w = '0, tgd_r, ttga, ttgc, ttgd_w, ttgd_r = '0;
    logic        ack, err, twe, tcyc, tstb;
    logic        tack = 1'b0, terr = 1'b0;

    int errors = 0;
    int checks = 0;

    wb_tag_target_slice #(
        .ADR_WIDTH(32), .DAT_WIDTH(32), .TGA_WIDTH(4), .TGC_WIDTH(4), .TGD_WIDTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .adr(adr), .dat_w(dat_w), .sel(sel), .we(we), .cyc(cyc), .stb(stb),
        .tga(tga), .tgc(tgc), .tgd_w(tgd_w),
        .dat_r(dat_r), .tgd_r(tgd_r), .ack(ack), .err(err),
        .tadr(tadr), .tdat_w(tdat_w), .tsel(tsel), .twe(twe), .tcyc(tcyc), .tstb(tstb),
        .ttga(ttga), .ttgc(ttgc), .ttgd_w(ttgd_w),
        .tdat_r(tdat_r), .ttgd_r(ttgd_r), .tack(tack), .terr(terr)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] adr;
        logic [31:0] dat_w;
        logic [3:0]  sel;
        logic        we;
        logic [3:0]  tga;
        logic [3:0]  tgc;
        logic [3:0]  tgd_w;
        int          rsp_at;
        bit          r_ack;
        bit          r_err;
        logic [31:0] r_dat;
        logic [3:0]  r_tgd;
        int          drop_at;
        int          exp_cycle;
        bit          exp_ack;
        bit          exp_err;
        logic [31:0] exp_dat;
        logic [3:0]  exp_tgd;
        bit          chk_tgd;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic w, input logic [3:0] ga,
                                input logic [3:0] gc, input logic [3:0] gd, input int rsp_at,
                                input bit r_ack, input bit r_err, input logic [31:0] r_dat,
                                input logic [3:0] r_tgd, input int drop_at, input int exp_cycle,
                                input bit exp_ack, input bit exp_err, input logic [31:0] exp_dat,
                                input logic [3:0] exp_tgd, input bit chk_tgd);
        vec_t v;
        v.name = name; v.adr = a; v.dat_w = d; v.sel = s; v.we = w;
        v.tga = ga; v.tgc = gc; v.tgd_w = gd;
        v.rsp_at = rsp_at; v.r_ack = r_ack; v.r_err = r_err; v.r_dat = r_dat; v.r_tgd = r_tgd;
        v.drop_at = drop_at; v.exp_cycle = exp_cycle; v.exp_ack = exp_ack; v.exp_err = exp_err;
        v.exp_dat = exp_dat; v.exp_tgd = exp_tgd; v.chk_tgd = chk_tgd;
        return v;
    endfunction

    // Transaction-level model: when the transfer ends, whether the initiator still wants it, and what it sees.
    function automatic vec_t refModel(input vec_t v);
        vec_t r;
        bit   timed_out;
        bit   delivered;
        int   done;
        r = v;
        timed_out   = TO_EN && (v.rsp_at > TIMEOUT);
        done        = timed_out ? TIMEOUT + 1 : v.rsp_at + 1;
        delivered   = (v.drop_at == 0) || (v.drop_at >= done);
        r.exp_cycle = done;
        r.exp_err   = delivered && (timed_out || v.r_err);
        r.exp_ack   = delivered && !r.exp_err;
        r.exp_dat   = r.exp_ack ? v.r_dat : 32'h0;
        r.exp_tgd   = r.exp_ack ? v.r_tgd : 4'h0;
        r.chk_tgd   = r.exp_ack || (delivered && timed_out);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Cycle 0 presents the request; cycle c is the c-th clock after it. Upstream inputs are scrambled
    // after acceptance so only latched values can appear downstream.
    task automatic applyStimulus(input vec_t v);
        int seen_cycle;
        int pulses;
        bit seen_err;
        bit stable_ok;
        bit drop_ok;
        bit delivered;
        seen_cycle = -1; pulses = 0; seen_err = 0; stable_ok = 1; drop_ok = 1;
        delivered = v.exp_ack || v.exp_err;
        @(posedge clock); #1;
        adr = v.adr; dat_w = v.dat_w; sel = v.sel; we = v.we;
        tga = v.tga; tgc = v.tgc; tgd_w = v.tgd_w;
        tdat_r = v.r_dat; ttgd_r = v.r_tgd;
        cyc = 1'b1; stb = 1'b1;
        for (int c = 1; c <= v.exp_cycle + 2; c++) begin
            @(posedge clock); #1;
            if (ack || err) begin
                if (seen_cycle < 0) seen_cycle = c;
                pulses += (ack && err) ? 100 : 1;
                seen_err = err;
            end
            if (c < v.exp_cycle) begin
                if (!(tcyc === 1'b1 && tstb === 1'b1 && tadr === v.adr && tdat_w === v.dat_w &&
                      tsel === v.sel && twe === v.we && ttga === v.tga && ttgc === v.tgc &&
                      ttgd_w === v.tgd_w))
                    stable_ok = 0;
            end else if (tcyc !== 1'b0 || tstb !== 1'b0) begin
                drop_ok = 0;
            end
            adr = ~v.adr; dat_w = ~v.dat_w; sel = ~v.sel; we = ~v.we;
            tga = ~v.tga; tgc = ~v.tgc; tgd_w = ~v.tgd_w;
            tack = (c == v.rsp_at) && v.r_ack;
            terr = (c == v.rsp_at) && v.r_err;
            if ((v.drop_at != 0 && c >= v.drop_at) || c >= v.exp_cycle) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        tack = 1'b0; terr = 1'b0; cyc = 1'b0; stb = 1'b0;
        checkOutput({v.name, " completion_cycle"}, seen_cycle, delivered ? v.exp_cycle : -1);
        checkOutput({v.name, " pulse_count"}, pulses, delivered ? 1 : 0);
        if (delivered) begin
            checkOutput({v.name, " err_vs_ack"}, 32'(seen_err), 32'(v.exp_err));
            checkOutput({v.name, " dat_r"}, dat_r, v.exp_dat);
        end
        if (v.chk_tgd) checkOutput({v.name, " tgd_r"}, 32'(tgd_r), 32'(v.exp_tgd));
        checkOutput({v.name, " request_stable"}, 32'(stable_ok), 32'd1);
        checkOutput({v.name, " tcyc_dropped"}, 32'(drop_ok), 32'd1);
    endtask

    vec_t table_v[12];
    vec_t rv;
    logic [15:0] ack_mask;

    initial begin
        table_v[0]  = mk("zero_wait_read", 32'h2800_0010, 32'h0, 4'hF, 1'b0, 4'h3, 4'h1, 4'h0,
                         1, 1, 0, 32'hDEAD_BEEF, 4'h5, 0, 2, 1, 0, 32'hDEAD_BEEF, 4'h5, 1);
        table_v[1]  = mk("wait_state_write", 32'h0000_0400, 32'h1234_5678, 4'hF, 1'b1, 4'hA, 4'h2, 4'h6,
                         4, 1, 0, 32'h0, 4'h0, 0, 5, 1, 0, 32'h0, 4'h0, 1);
        table_v[2]  = mk("terr_with_tack", 32'h0000_0800, 32'h0, 4'h3, 1'b0, 4'h1, 4'h1, 4'h1,
                         2, 1, 1, 32'h5555_AAAA, 4'h7, 0, 3, 0, 1, 32'h0, 4'h0, 0);
        table_v[3]  = mk("terr_only", 32'h0000_0C00, 32'hFFFF_0000, 4'hC, 1'b1, 4'h2, 4'h3, 4'h4,
                         3, 0, 1, 32'h7777_7777, 4'h3, 0, 4, 0, 1, 32'h0, 4'h0, 0);
        table_v[4]  = mk("upstream_abandon", 32'h0000_1000, 32'h0, 4'hF, 1'b0, 4'h5, 4'h0, 4'h0,
                         5, 1, 0, 32'h1111_1111, 4'h1, 2, 6, 0, 0, 32'h0, 4'h0, 0);
        table_v[5]  = mk("after_abandon", 32'h0000_1004, 32'h0, 4'hF, 1'b0, 4'h6, 4'h1, 4'h0,
                         1, 1, 0, 32'h0BAD_F00D, 4'h9, 0, 2, 1, 0, 32'h0BAD_F00D, 4'h9, 1);
        table_v[6]  = mk("tack_on_timeout_cycle", 32'h0000_2000, 32'h0, 4'hF, 1'b0, 4'h7, 4'h2, 4'h0,
                         8, 1, 0, 32'h8765_4321, 4'h2, 0, 9, 1, 0, 32'h8765_4321, 4'h2, 1);
        table_v[7]  = mk("terr_on_timeout_cycle", 32'h0000_2004, 32'h0, 4'hF, 1'b0, 4'h8, 4'h2, 4'h0,
                         8, 0, 1, 32'h0, 4'h0, 0, 9, 0, 1, 32'h0, 4'h0, 0);
        table_v[8]  = mk("late_tack", 32'h0000_3000, 32'h0, 4'hF, 1'b0, 4'h9, 4'h0, 4'h0,
                         9, 1, 0, 32'h1357_9BDF, 4'h4, 0, TO_EN ? 9 : 10, !TO_EN, TO_EN,
                         TO_EN ? 32'h0 : 32'h1357_9BDF, TO_EN ? 4'h0 : 4'h4, 1);
        table_v[9]  = mk("silent_target", 32'h0000_4000, 32'h0, 4'hF, 1'b0, 4'hB, 4'h0, 4'h0,
                         1005, 1, 0, 32'hCAFE_F00D, 4'h1, 0, TO_EN ? 9 : 1006, !TO_EN, TO_EN,
                         TO_EN ? 32'h0 : 32'hCAFE_F00D, TO_EN ? 4'h0 : 4'h1, 1);
        table_v[10] = mk("drop_last_req_cycle", 32'h0000_5000, 32'h0, 4'hF, 1'b0, 4'hC, 4'h0, 4'h0,
                         3, 1, 0, 32'h9999_0000, 4'h8, 3, 4, 0, 0, 32'h0, 4'h0, 0);
        table_v[11] = mk("drop_after_response", 32'h0000_6000, 32'h0, 4'hF, 1'b0, 4'hD, 4'h0, 4'h0,
                         3, 1, 0, 32'h2468_1357, 4'hB, 5, 4, 1, 0, 32'h2468_1357, 4'hB, 1);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_flags", {28'h0, ack, err, tcyc, tstb}, 32'h0);
        checkOutput("reset_tadr", tadr, 32'h0);
        checkOutput("reset_dat_r", dat_r, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) applyStimulus(table_v[i]);

        for (int i = 0; i < 24; i++) begin
            rv.name    = $sformatf("random_%0d", i);
            rv.adr     = $urandom;
            rv.dat_w   = $urandom;
            rv.sel     = 4'($urandom_range(0, 15));
            rv.we      = 1'($urandom_range(0, 1));
            rv.tga     = 4'($urandom_range(0, 15));
            rv.tgc     = 4'($urandom_range(0, 15));
            rv.tgd_w   = 4'($urandom_range(0, 15));
            rv.rsp_at  = int'($urandom_range(1, 12));
            rv.r_err   = ($urandom_range(0, 3) == 0);
            rv.r_ack   = rv.r_err ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.r_dat   = $urandom;
            rv.r_tgd   = 4'($urandom_range(0, 15));
            rv.drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            applyStimulus(refModel(rv));
        end

        // Initiator holding cyc/stb against a zero-wait target: one ack every third cycle.
        ack_mask = '0;
        @(posedge clock); #1;
        adr = 32'h0000_7000; cyc = 1'b1; stb = 1'b1; tack = 1'b1; tdat_r = 32'hA5A5_5A5A;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clock); #1;
            if (ack === 1'b1) ack_mask[c] = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; tack = 1'b0;
        checkOutput("back_to_back_ack_cycles", 32'(ack_mask), 32'h124);

        // Asynchronous reset between clock edges while REQ is in flight.
        @(posedge clock); #1;
        adr = 32'h0000_8000; tga = 4'hE; cyc = 1'b1; stb = 1'b1;
        @(posedge clock); #1;
        checkOutput("areset_pre_tcyc", 32'(tcyc), 32'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset_flags", {28'h0, ack, err, tcyc, tstb}, 32'h0);
        checkOutput("areset_tadr_ttga", {tadr[27:0], ttga}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        #2 reset = 1'b1;
        applyStimulus(table_v[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
